// File: rtl/mul_div_unit_if.sv
// Start/Busy/Done request bus between the control unit and the iterative M-extension unit.
interface mul_div_unit_if #(
    parameter int XLEN = 32
);
    logic            Start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic [XLEN-1:0] Result;
    logic            Busy;
    logic            Done;

    modport master (
        output Start, funct3, SrcA, SrcB,
        input  Result, Busy, Done
    );

    modport slave (
        input  Start, funct3, SrcA, SrcB,
        output Result, Busy, Done
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M/RV64M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up in a final cycle.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_result;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_divz;
    logic              r_busy;
    logic              r_done;

    logic              w_sgn_a;
    logic              w_sgn_b;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_trial;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_res;

    always_comb begin
        w_sgn_a = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                  (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        w_sgn_b = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                  (bus.funct3 == 3'b110);
        w_sa    = w_sgn_a & bus.SrcA[XLEN-1];
        w_sb    = w_sgn_b & bus.SrcB[XLEN-1];
        w_mag_a = w_sa ? -bus.SrcA : bus.SrcA;
        w_mag_b = w_sb ? -bus.SrcB : bus.SrcB;
    end

    // r_a holds the multiplicand (multiply) or divisor (divide); r_lo the multiplier or dividend.
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
        w_shift  = {r_hi, r_lo[XLEN-1]};
        w_trial  = w_shift - {1'b0, r_a};
        w_prod   = {r_hi, r_lo};
        w_prod_s = r_neg_q ? -w_prod : w_prod;
        w_quot   = r_divz ? '1 : (r_neg_q ? -r_lo : r_lo);
        w_rem    = r_neg_r ? -r_hi : r_hi;
        if (r_op[2])
            w_res = r_op[1] ? w_rem : w_quot;
        else if (r_op[1:0] == 2'b00)
            w_res = w_prod_s[XLEN-1:0];
        else
            w_res = w_prod_s[2*XLEN-1:XLEN];
    end

    // Busy/Done trail the state by one cycle so they never overlap on a DONE->RUN restart.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_divz   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= (r_state == S_RUN) || (r_state == S_FIX);
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.Start) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_op    <= bus.funct3;
                        r_a     <= bus.funct3[2] ? w_mag_b : w_mag_a;
                        r_lo    <= bus.funct3[2] ? w_mag_a : w_mag_b;
                        r_hi    <= '0;
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        r_divz  <= (bus.SrcB == '0);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (r_op[2]) begin
                        r_hi <= w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], ~w_trial[XLEN]};
                    end else begin
                        r_hi <= w_sum[XLEN:1];
                        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(XLEN - 1))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result <= w_res;
                    r_state  <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.Result = r_result;
    assign bus.Busy   = r_busy;
    assign bus.Done   = r_done;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit (XLEN=32): results, fixed latency, handshake and reset.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mul_div_unit_if #(.XLEN(32)) bus ();

    mul_div_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called #1 after an accepting edge; returns cycles until Done is seen (0 on timeout).
    task automatic wait_done(output int cyc, output int busy_cyc, output int overlap);
        bit seen;
        seen     = 1'b0;
        cyc      = 0;
        busy_cyc = 0;
        overlap  = 0;
        for (int i = 1; i <= 100 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.Busy) busy_cyc++;
            if (bus.Busy && bus.Done) overlap++;
            if (bus.Done) begin
                cyc  = i;
                seen = 1'b1;
            end
        end
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.Done) pulses++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int cyc, bc, ov;
        bus.Start  = 1'b1;
        bus.funct3 = op;
        bus.SrcA   = a;
        bus.SrcB   = b;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        bus.SrcA  = ~a;
        bus.SrcB  = ~b;
        wait_done(cyc, bc, ov);
        chk({tag, " result"}, bus.Result, exp);
        chk({tag, " latency"}, cyc, 34);
        chk({tag, " busy_cycles"}, bc, 33);
        chk({tag, " busy_done_overlap"}, ov, 0);
    endtask

    initial begin
        int cyc, bc, ov, pulses;

        reset      = 1'b1;
        bus.Start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.SrcA   = 32'd3;
        bus.SrcB   = 32'd4;
        repeat (3) @(posedge clk);
        #1;
        chk("reset Result", bus.Result, 32'h0);
        chk("reset Busy", {31'b0, bus.Busy}, 32'h0);
        chk("reset Done", {31'b0, bus.Done}, 32'h0);
        bus.Start = 1'b0;
        reset     = 1'b0;
        @(posedge clk);
        #1;

        run_op("MUL",        3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
        run_op("MULH",       3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
        run_op("MULHU",      3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("MULHSU",     3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("MULH_neg",   3'b001, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF);
        run_op("DIV",        3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
        run_op("REM",        3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
        run_op("DIVU",       3'b101, 32'd100,      32'd7,        32'd14);
        run_op("REMU",       3'b111, 32'd100,      32'd7,        32'd2);
        run_op("DIVU_by0",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF);
        run_op("REMU_by0",   3'b111, 32'd5,        32'd0,        32'd5);
        run_op("DIV_by0",    3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF);
        run_op("REM_by0",    3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9);
        run_op("DIV_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_op("REM_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0);

        // Start pulsed mid-run with different operands must be ignored.
        bus.Start  = 1'b1;
        bus.funct3 = 3'b101;
        bus.SrcA   = 32'd100;
        bus.SrcB   = 32'd7;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.Start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.SrcA   = 32'd9;
        bus.SrcB   = 32'd9;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        wait_done(cyc, bc, ov);
        chk("ignore_start result", bus.Result, 32'd14);
        chk("ignore_start latency", (cyc == 0) ? 0 : cyc + 6, 34);
        count_done(40, pulses);
        chk("ignore_start extra_done", pulses, 0);

        // Start held high: ignored during RUN, accepted again in DONE.
        bus.Start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.SrcA   = 32'd7;
        bus.SrcB   = 32'hFFFFFFFD;
        @(posedge clk);
        #1;
        bus.funct3 = 3'b011;
        bus.SrcA   = 32'hFFFFFFFF;
        bus.SrcB   = 32'hFFFFFFFF;
        wait_done(cyc, bc, ov);
        bus.Start = 1'b0;
        chk("b2b first result", bus.Result, 32'hFFFFFFEB);
        chk("b2b first latency", cyc, 34);
        chk("b2b first overlap", ov, 0);
        wait_done(cyc, bc, ov);
        chk("b2b second result", bus.Result, 32'hFFFFFFFE);
        chk("b2b second latency", cyc, 34);
        chk("b2b second busy_cycles", bc, 33);
        chk("b2b second overlap", ov, 0);

        // Reset in the middle of RUN abandons the operation.
        bus.Start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.SrcA   = 32'd7;
        bus.SrcB   = 32'd6;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_reset Busy", {31'b0, bus.Busy}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrun_reset Busy", {31'b0, bus.Busy}, 32'h0);
        chk("midrun_reset Done", {31'b0, bus.Done}, 32'h0);
        chk("midrun_reset Result", bus.Result, 32'h0);
        count_done(40, pulses);
        chk("midrun_reset no_done", pulses, 0);
        run_op("after_reset MUL", 3'b000, 32'd7, 32'd6, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
